// File: rtl/pipelined_carry_select_adder_if.sv
// Valid/ready stream bundle for pipelined_carry_select_adder.
// The ovf signal exists only when CSA_OVERFLOW_EN is defined.
interface pipelined_carry_select_adder_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSA_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, in1, in2, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, in1, in2, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_carry_select_adder.sv
// Parametrised pipelined carry-select adder with a single global advance for backpressure.
// Optional signed-overflow output is enabled by defining CSA_OVERFLOW_EN.
module pipelined_carry_select_adder #(
    parameter int WIDTH  = 32,
    parameter int BLOCK  = 4,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    pipelined_carry_select_adder_if.slave io_bus
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int BPS  = (NBLK + STAGES - 1) / STAGES;

    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];
    logic             r_v   [STAGES];

    logic [WIDTH-1:0] w_st_a   [STAGES];
    logic [WIDTH-1:0] w_st_b   [STAGES];
    logic [WIDTH-1:0] w_st_sum [STAGES];
    logic             w_st_c   [STAGES];
    logic             w_st_v   [STAGES];
    logic [WIDTH-1:0] w_nsum   [STAGES];
    logic             w_nc     [STAGES];
    logic [BLOCK:0]   w_r0;
    logic [BLOCK:0]   w_r1;
    logic             w_adv;

    assign w_adv            = !r_v[STAGES-1] || io_bus.out_ready;
    assign io_bus.in_ready  = w_adv;
    assign io_bus.out_valid = r_v[STAGES-1];
    assign io_bus.sum       = r_sum[STAGES-1];
    assign io_bus.cout      = r_c[STAGES-1];

    // Stage s consumes the previous stage's registers; stage 0 sees the input beat.
    always_comb begin
        w_st_a[0]   = io_bus.in1;
        w_st_b[0]   = io_bus.in2;
        w_st_sum[0] = '0;
        w_st_c[0]   = io_bus.cin;
        w_st_v[0]   = io_bus.in_valid;
        for (int s = 1; s < STAGES; s++) begin
            w_st_a[s]   = r_a[s-1];
            w_st_b[s]   = r_b[s-1];
            w_st_sum[s] = r_sum[s-1];
            w_st_c[s]   = r_c[s-1];
            w_st_v[s]   = r_v[s-1];
        end
    end

    // Block j belongs to stage j/BPS; block 0 ripples cin, later blocks select on the block carry.
    always_comb begin
        w_r0 = '0;
        w_r1 = '0;
        for (int s = 0; s < STAGES; s++) begin
            w_nsum[s] = w_st_sum[s];
            w_nc[s]   = w_st_c[s];
            for (int j = 0; j < NBLK; j++) begin
                if (j / BPS == s) begin
                    w_r0 = {1'b0, w_st_a[s][j*BLOCK +: BLOCK]} + {1'b0, w_st_b[s][j*BLOCK +: BLOCK]};
                    if (j == 0) begin
                        {w_nc[s], w_nsum[s][j*BLOCK +: BLOCK]} = w_r0 + {{BLOCK{1'b0}}, w_nc[s]};
                    end else begin
                        w_r1 = w_r0 + {{BLOCK{1'b0}}, 1'b1};
                        {w_nc[s], w_nsum[s][j*BLOCK +: BLOCK]} = w_nc[s] ? w_r1 : w_r0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_v[s]   <= 1'b0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
            end
        end else if (w_adv) begin
            for (int s = 0; s < STAGES; s++) begin
                r_v[s]   <= w_st_v[s];
                r_a[s]   <= w_st_a[s];
                r_b[s]   <= w_st_b[s];
                r_sum[s] <= w_nsum[s];
                r_c[s]   <= w_nc[s];
            end
        end
    end

`ifdef CSA_OVERFLOW_EN
    logic r_ovf;
    logic w_ovf_n;

    // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
    assign w_ovf_n = w_st_a[STAGES-1][WIDTH-1] ^ w_st_b[STAGES-1][WIDTH-1]
                   ^ w_nsum[STAGES-1][WIDTH-1] ^ w_nc[STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_ovf <= w_ovf_n;
        end
    end

    assign io_bus.ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Scoreboard bench for pipelined_carry_select_adder (WIDTH=8/STAGES=2, plus a WIDTH=32/STAGES=8 instance).
// Exercises the ovf output when CSA_OVERFLOW_EN is defined.
module tb_pipelined_carry_select_adder;
    localparam int W = 8;
    localparam int B = 4;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_carry_select_adder_if #(.WIDTH(W)) bus ();
    pipelined_carry_select_adder #(.WIDTH(W), .BLOCK(B), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .io_bus(bus)
    );

    pipelined_carry_select_adder_if #(.WIDTH(32)) bus32 ();
    pipelined_carry_select_adder #(.WIDTH(32), .BLOCK(4), .STAGES(8)) u_dut32 (
        .clk(clk), .rst(rst), .io_bus(bus32)
    );

    exp_t         sb_q[$];
    int           n_checks  = 0;
    int           n_pass    = 0;
    int           cyc       = 0;
    int           head_seen = -1;
    bit           chk_lat   = 1'b0;
    bit           hold_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_cout;
    logic         held_ovf;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true signed result range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int acc);
        exp_t        e;
        logic [31:0] u;
        int          sg;
        u      = 32'(a) + 32'(b) + 32'(c);
        e.sum  = u[W-1:0];
        e.cout = (u >= (32'd1 << W));
        sg     = int'($signed(a)) + int'($signed(b)) + int'(c);
        e.ovf  = (sg > (2**(W-1)) - 1) || (sg < -(2**(W-1)));
        e.acc  = acc;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            hold_prev = 1'b0;
            head_seen = -1;
        end else begin
            chk("in_ready_rule", bus.in_ready, (!bus.out_valid || bus.out_ready) ? 1 : 0);
            if (hold_prev) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_sum", bus.sum, held_sum);
                chk("stall_cout", bus.cout, held_cout);
`ifdef CSA_OVERFLOW_EN
                chk("stall_ovf", bus.ovf, held_ovf);
`endif
            end
            if (bus.out_valid) begin
                if (head_seen < 0) head_seen = cyc;
                if (bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_out: got beat sum 0x%0h, expected no beat", bus.sum);
                    end else begin
                        e = sb_q.pop_front();
                        chk("sum", bus.sum, e.sum);
                        chk("cout", bus.cout, e.cout);
`ifdef CSA_OVERFLOW_EN
                        chk("ovf", bus.ovf, e.ovf);
`endif
                        if (chk_lat) chk("latency", longint'(head_seen - e.acc), S);
                    end
                    head_seen = -1;
                end
            end
            hold_prev = bus.out_valid && !bus.out_ready;
            held_sum  = bus.sum;
            held_cout = bus.cout;
`ifdef CSA_OVERFLOW_EN
            held_ovf  = bus.ovf;
`else
            held_ovf  = 1'b0;
`endif
            if (bus.in_valid && bus.in_ready) sb_q.push_back(model(bus.in1, bus.in2, bus.cin, cyc));
        end
    end

    // Every driver task starts and ends 1 time unit after a rising edge.
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bit ok;
        ok           = 1'b0;
        bus.in_valid = 1'b1;
        bus.in1      = a;
        bus.in2      = b;
        bus.cin      = c;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready 0 for 200 cycles, expected acceptance");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200; k++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          ok;
        int          idx;
        int          lat;
        int          acc_n;
        logic [W-1:0] bp_a [6];
        logic [W-1:0] bp_b [6];
        logic         bp_c [6];
        logic [32:0]  e32;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in1       = '0;
        bus.in2       = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.in1       = '0;
        bus32.in2       = '0;
        bus32.cin       = 1'b0;
        bus32.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid32", bus32.out_valid, 0);
`ifdef CSA_OVERFLOW_EN
        chk("rst_ovf", bus.ovf, 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed sums, back to back with no stall; the first beat follows reset release directly.
        chk_lat = 1'b1;
        send_beat(8'h01, 8'h00, 1'b0);
        send_beat(8'h0A, 8'h03, 1'b0);
        send_beat(8'hD0, 8'hA0, 1'b1);
        send_beat(8'hFF, 8'h00, 1'b1);
        send_beat(8'hFF, 8'hFF, 1'b1);
`ifdef CSA_OVERFLOW_EN
        send_beat(8'h7F, 8'h01, 1'b0);
        send_beat(8'h80, 8'h80, 1'b0);
        send_beat(8'h05, 8'h03, 1'b0);
`endif
        drain();
        chk_lat = 1'b0;

        // Backpressure: six beats, out_ready low in cycles 3..5.
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = W'($urandom);
            bp_b[i] = W'($urandom);
            bp_c[i] = 1'($urandom);
        end
        idx = 0;
        for (int c = 1; c <= 40; c++) begin
            bus.in_valid  = (idx < 6);
            bus.in1       = bp_a[idx % 6];
            bus.in2       = bp_b[idx % 6];
            bus.cin       = bp_c[idx % 6];
            bus.out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            if (c >= 3 && c <= 5) chk("bp_in_ready", bus.in_ready, 0);
            @(posedge clk);
            #1;
            if (ok) idx++;
            if (idx == 6 && c > 5) break;
        end
        chk("bp_all_sent", idx, 6);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Mid-stream reset with two beats in flight.
        bus.out_ready = 1'b0;
        send_beat(8'h12, 8'h34, 1'b0);
        send_beat(8'h56, 8'h21, 1'b1);
        chk("pre_rst_out_valid", bus.out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_sum", bus.sum, 0);
        chk("midrst_cout", bus.cout, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        sb_q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_beat", bus.out_valid, 0);
        end
        @(posedge clk);
        #1;
        chk_lat = 1'b1;
        send_beat(8'h9C, 8'h77, 1'b1);
        drain();
        chk_lat = 1'b0;

        // Wide instance: full carry chain through eight stages.
        bus32.in1      = 32'hFFFF_FFFF;
        bus32.in2      = 32'h0000_0000;
        bus32.cin      = 1'b1;
        bus32.in_valid = 1'b1;
        e32 = 33'(bus32.in1) + 33'(bus32.in2) + 33'(bus32.cin);
        @(negedge clk);
        chk("w32_in_ready", bus32.in_ready, 1);
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus32.out_valid) begin
                lat = k;
                break;
            end
        end
        chk("w32_latency", lat, 8);
        chk("w32_sum", bus32.sum, e32[31:0]);
        chk("w32_cout", bus32.cout, e32[32]);
        @(posedge clk);
        #1;

        // Random traffic with random valid and ready.
        acc_n = 0;
        for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in1       = W'($urandom);
            bus.in2       = W'($urandom);
            bus.cin       = 1'($urandom);
            @(negedge clk);
            ok = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (ok) acc_n++;
        end
        chk("rand_beats_sent", acc_n, 10000);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_carry_select_adder.md
# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder with a valid/ready stream interface. It is the next generation of the fixed 8-bit carry-select adder: operand width, carry-select block size and pipeline depth are parameters, and it adds backpressure handling. It sits in the adder library as the final carry-propagate stage behind the multiplier reduction trees. It also works as a standalone streaming adder.

## Interface
- `WIDTH`, 32: operand and sum width. Must be a multiple of `BLOCK`.
- `BLOCK`, 4: carry-select block size in bits. `NBLK = WIDTH/BLOCK`.
- `STAGES`, 2: number of pipeline register stages. Legal range is 1..`NBLK`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand beat present.
- `in_ready`  out  1  block accepts the beat this cycle.
- `in1`  in  `WIDTH`  operand A.
- `in2`  in  `WIDTH`  operand B.
- `cin`  in  1  carry-in.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts the result.
- `sum`  out  `WIDTH`  `(in1+in2+cin) mod 2^WIDTH`.
- `cout`  out  1  carry out of bit `WIDTH-1`.
- `ovf`  out  1  signed overflow; present only with `CSA_OVERFLOW_EN`.

## Operation
- **Block structure.**
  - Block 0 is a ripple adder driven by `cin`.
  - Each block j ≥ 1 computes two results in parallel, one for carry-in 0 and one for carry-in 1.
  - The incoming block carry selects between them via a mux.
- **Stage partitioning.**
  - Blocks are assigned to stages in order, `ceil(NBLK/STAGES)` blocks per stage; the last stage takes the remainder.
  - Each stage registers:
    - its partial sum bits so far,
    - the carry out of its last block,
    - the unconsumed operand bits, which are delayed to the stage that uses them.
- **Results.** Results are bit-exact to `{cout,sum} = in1 + in2 + cin`, with unsigned arithmetic and `WIDTH+1`-bit result.
- **Flow control.**
  - Global advance condition: `adv = !out_valid || out_ready`.
  - When `adv=1`, every stage shifts forward by one.
  - When `adv=0`, all stages hold.
  - `in_ready = adv`, combinationally.
- **Accepting a beat.** A beat is accepted when `in_valid && in_ready`.
  - Each stage carries a valid bit.
  - Stage 0's valid bit loads `in_valid` whenever `adv=1`.
  - Bubbles propagate as invalid stages and never produce `out_valid`.
- **Output stability.** While `out_valid=1` and `out_ready=0`, the outputs `sum`, `cout` and `ovf` must hold stable.
- **Ordering.** No beats are dropped, duplicated or reordered.

## Timing
- **Reset.**
  - On `rst` assertion, all valid bits clear asynchronously.
  - Outputs after reset: `out_valid=0`, `sum=0`, `cout=0`, `ovf=0`, and `in_ready=1`.
  - Asserting `rst` mid-operation discards all in-flight beats.
  - The first beat after `rst` deasserts is accepted on the first rising edge at which it is presented.
- **Latency.** Exactly `STAGES` cycles from the acceptance edge to `out_valid` rising, provided no stall occurs.
- **Throughput.** One beat per cycle while `out_ready=1`.
- **Stalls.**
  - A stall of N cycles adds N cycles of latency to every beat in flight.
  - Data registers load only when `adv=1`; invalid stages may load arbitrary data.
- **Simultaneous accept and emit.** Accepting a new beat and emitting the oldest beat in the same cycle is legal and must occur when the pipeline is full and `out_ready=1`.
- **Boundary cases.**
  - All-ones operands with `cin=1` propagate the carry through every block and every stage.
  - `STAGES=1` yields a single register stage at the output.
  - `STAGES=NBLK` registers after every block.

## Configuration
- Macro: `CSA_OVERFLOW_EN`.
- **Defined:**
  - The `ovf` port exists.
  - `ovf = carry into bit WIDTH-1 XOR cout`.
  - `ovf` is pipelined alongside `sum` and has the same latency, stall and reset behaviour.
- **Undefined:**
  - No `ovf` port and no related logic.
  - All other behaviour is identical.

## Test plan
- Use `WIDTH=8`, `BLOCK=4`, `STAGES=2` unless stated otherwise.
- **Reset:** assert `rst` mid-stream with 2 beats in flight -> `out_valid=0` and `sum=0` immediately; the two beats never appear.
- **Directed sums:**
  - `in1=0x01`, `in2=0x00`, `cin=0` -> `sum=0x01`, `cout=0`.
  - `in1=0x0A`, `in2=0x03`, `cin=0` -> `sum=0x0D`, `cout=0`.
  - `in1=0xD0`, `in2=0xA0`, `cin=1` -> `sum=0x71`, `cout=1`.
  - Each result appears exactly 2 cycles after acceptance.
- **Full carry chain:** `in1=0xFF`, `in2=0x00`, `cin=1` -> `sum=0x00`, `cout=1`.
  - Repeat at `WIDTH=32`, `STAGES=8` -> `sum=0`, `cout=1`, latency 8.
- **Backpressure:** stream 6 beats with `in_valid` held high and `out_ready` low for cycles 3-5.
  - `in_ready` must be 0 during the stall.
  - Results must arrive in order and unchanged, with `sum` stable while stalled.
- **Overflow (`CSA_OVERFLOW_EN` defined):**
  - `0x7F+0x01` -> `ovf=1`, `sum=0x80`.
  - `0x80+0x80` -> `ovf=1`, `cout=1`.
  - `0x05+0x03` -> `ovf=0`.
- **Random:** 10k random operand/`cin` beats with random `in_valid` and `out_ready` -> every result matches `in1+in2+cin`, with no loss or reordering.
